alu_op_sequencer: RTL and testbench

Front-end issuer for the team's 8-bit combinational ALU. It accepts tagged operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand and select inputs from registers, captures the ALU result and flags one cycle later, and returns them in order over a second valid/ready handshake. It sits between the control path and the ALU so the ALU itself stays purely combinational.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_fifo.sv | 53 +++++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } seq_state_e;

  // Tag width is a module parameter, so the tag is stored alongside this record.
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
module alu_seq_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers tagged ALU commands, drives a combinational ALU from registers and returns
// results in order. Define ALU_SEQ_STATS_EN to add the 16-bit op_count_o response counter.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned TagW      = 4,
  parameter int unsigned FifoDepth = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [7:0]      cmd_a_i,
  input  logic [7:0]      cmd_b_i,
  input  logic [TagW-1:0] cmd_tag_i,
  output logic [7:0]      alu_a_o,
  output logic [7:0]      alu_b_o,
  output logic [1:0]      alu_sel_o,
  input  logic [7:0]      alu_out_i,
  input  logic            alu_carry_i,
  input  logic            alu_zero_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [7:0]      rsp_data_o,
  output logic            rsp_carry_o,
  output logic            rsp_zero_o,
  output logic [TagW-1:0] rsp_tag_o,
  output logic            busy_o
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]     op_count_o
`endif
);

  localparam int unsigned CmdW = $bits(alu_cmd_t) + TagW;

  seq_state_e      state_q;
  logic [7:0]      alu_a_q, alu_b_q;
  logic [1:0]      alu_sel_q;
  logic [TagW-1:0] tag_q;
  logic            rsp_valid_q, rsp_carry_q, rsp_zero_q;
  logic [7:0]      rsp_data_q;
  logic [TagW-1:0] rsp_tag_q;

  logic [CmdW-1:0] fifo_wdata, fifo_rdata;
  logic            fifo_full, fifo_empty;
  alu_cmd_t        head_cmd;
  logic [TagW-1:0] head_tag;
  logic            pop;

  assign fifo_wdata           = {cmd_tag_i, cmd_op_i, cmd_a_i, cmd_b_i};
  assign {head_tag, head_cmd} = fifo_rdata;

  alu_seq_fifo #(
    .Width (CmdW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid_i),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pop either from idle or when the current response is consumed.
  assign pop = ~fifo_empty &
               ((state_q == StIdle) | ((state_q == StResp) & rsp_ready_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      if (pop) begin
        alu_a_q   <= head_cmd.a;
        alu_b_q   <= head_cmd.b;
        alu_sel_q <= head_cmd.op;
        tag_q     <= head_tag;
      end
      case (state_q)
        StIdle: begin
          if (pop) state_q <= StIssue;
        end
        StIssue: begin
          rsp_data_q  <= alu_out_i;
          rsp_zero_q  <= alu_zero_i;
          rsp_carry_q <= alu_carry_i & (alu_sel_q == OP_ADD);
          rsp_tag_q   <= tag_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= pop ? StIssue : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count_o = op_count_q;
`endif

  assign cmd_ready_o = ~fifo_full;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_sel_o   = alu_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_carry_o = rsp_carry_q;
  assign rsp_zero_o  = rsp_zero_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign busy_o      = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached to its outputs.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned TagW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [7:0]      cmd_a = '0, cmd_b = '0;
  logic [TagW-1:0] cmd_tag = '0;
  logic [7:0]      alu_a, alu_b, alu_out;
  logic [1:0]      alu_sel;
  logic            alu_carry, alu_zero;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [7:0]      rsp_data;
  logic            rsp_carry, rsp_zero;
  logic [TagW-1:0] rsp_tag;
  logic            busy;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]     op_count;
`endif

  int checks = 0;
  int errors = 0;
  int nhs = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .TagW      (TagW),
    .FifoDepth (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_tag_i   (cmd_tag),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_sel_o   (alu_sel),
    .alu_out_i   (alu_out),
    .alu_carry_i (alu_carry),
    .alu_zero_i  (alu_zero),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_carry_o (rsp_carry),
    .rsp_zero_o  (rsp_zero),
    .rsp_tag_o   (rsp_tag),
    .busy_o      (busy)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count_o  (op_count)
`endif
  );

  // Behavioural 8-bit ALU; carry is bit 8 of a+b regardless of select.
  logic [8:0]  sum;
  logic [15:0] prod;
  always_comb begin
    sum  = {1'b0, alu_a} + {1'b0, alu_b};
    prod = 16'(alu_a) * 16'(alu_b);
    case (alu_sel)
      OP_ADD:  alu_out = sum[7:0];
      OP_MUL:  alu_out = prod[7:0];
      OP_XOR:  alu_out = alu_a ^ alu_b;
      default: alu_out = {alu_a[6:0], 1'b0};
    endcase
    alu_carry = sum[8];
    alu_zero  = (alu_out == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [TagW-1:0] tag);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Latency counts clock edges from the accepting edge until rsp_valid is visible.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [TagW-1:0] tag, input logic [7:0] exp_d,
                       input logic exp_c, input logic exp_z);
    int lat;
    send(op, a, b, tag);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("rsp_data", 32'(rsp_data), 32'(exp_d));
    check("rsp_carry", 32'(rsp_carry), 32'(exp_c));
    check("rsp_zero", 32'(rsp_zero), 32'(exp_z));
    check("rsp_tag", 32'(rsp_tag), 32'(tag));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    nhs++;
    check("rsp_drop", 32'(rsp_valid), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  int exp_rdy [4] = '{1, 1, 1, 0};
  int got_tag [4];
  int got_cyc [4];
  int ng;
  bit hold;
  bit stale;
  int n;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_tag", 32'(rsp_tag), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_sel", 32'(alu_sel), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single operations: 200+100 wraps to 0x2C with carry
    do_op(OP_ADD, 8'hC8, 8'h64, 4'd3, 8'h2C, 1'b1, 1'b0);
    check("alu_a_hold", 32'(alu_a), 32'h C8);
    check("alu_sel_hold", 32'(alu_sel), 32'(OP_ADD));
    do_op(OP_ADD, 8'h80, 8'h80, 4'd4, 8'h00, 1'b1, 1'b1);
    do_op(OP_XOR, 8'hFF, 8'hFF, 4'd5, 8'h00, 1'b0, 1'b1);
    check("alu_sel_xor", 32'(alu_sel), 32'(OP_XOR));
    do_op(OP_MUL, 8'h10, 8'h11, 4'd6, 8'h10, 1'b0, 1'b0);
    do_op(OP_SHL, 8'h81, 8'h80, 4'd7, 8'h02, 1'b0, 1'b0);

    // Backpressure: three fit (one in flight + two buffered), fourth stalls
    for (int k = 0; k < 4; k++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_a     = 8'(k);
      cmd_b     = 8'h01;
      cmd_tag   = TagW'(k + 1);
      check("bp_ready", 32'(cmd_ready), exp_rdy[k]);
      if (k < 3) @(negedge clk);
    end
    rsp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      if (rsp_valid) begin
        got_tag[ng] = int'(rsp_tag);
        got_cyc[ng] = c;
        ng++;
      end
      hold = cmd_valid && cmd_ready;
      @(negedge clk);
      if (hold) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    nhs += ng;
    check("bp_count", ng, 4);
    for (int i = 0; i < 4; i++) check("bp_tag", got_tag[i], i + 1);
    for (int i = 1; i < 4; i++) check("bp_gap", got_cyc[i] - got_cyc[i-1], 2);
    @(negedge clk);
    check("bp_busy", 32'(busy), 0);
    check("bp_cmd_ready", 32'(cmd_ready), 1);
`ifdef ALU_SEQ_STATS_EN
    check("op_count", 32'(op_count), nhs);
`endif

    // Reset while holding a response
    send(OP_ADD, 8'h01, 8'h02, 4'd9);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_valid", 32'(rsp_valid), 1);
    #2;
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_data", 32'(rsp_data), 0);
    check("mid_rst_tag", 32'(rsp_tag), 0);
    check("mid_rst_alu_a", 32'(alu_a), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    check("rst_ignores_cmd", 32'(busy), 0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    nhs       = 0;
    stale     = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stale |= rsp_valid | busy;
    end
    check("no_stale_rsp", 32'(stale), 0);
    do_op(OP_XOR, 8'h5A, 8'hA5, 4'hA, 8'hFF, 1'b0, 1'b0);
`ifdef ALU_SEQ_STATS_EN
    check("op_count_after_rst", 32'(op_count), nhs);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
